// File: rtl/ysyx_25010008_axi_pkg.sv
// rtl/ysyx_25010008_axi_pkg.sv - AXI-Lite widths, response codes and slave state type
package ysyx_25010008_axi_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_R_WAIT,
    ST_R_RESP,
    ST_W_DATA,
    ST_W_WAIT,
    ST_B_RESP
  } slave_state_e;

endpackage

// File: rtl/ysyx_25010008_sram_array.sv
// rtl/ysyx_25010008_sram_array.sv - synchronous byte-masked word RAM with registered read data
module ysyx_25010008_sram_array
  import ysyx_25010008_axi_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    rd_data_q <= mem_q[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ysyx_25010008_sram_slave.sv
// rtl/ysyx_25010008_sram_slave.sv - AXI4-Lite slave memory with fixed response latency
module ysyx_25010008_sram_slave
  import ysyx_25010008_axi_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [29:0]      BASE_WORD = BASE_ADDR[31:2];

  function automatic logic [IDX_W-1:0] word_idx(input logic [29:0] aw);
    return IDX_W'(aw - BASE_WORD);
  endfunction

  function automatic logic addr_ok(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2] - BASE_WORD;
    return (a >= BASE_ADDR) && ({2'b00, w} < 32'(DEPTH_WORDS));
  endfunction

  slave_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              bvalid_q, bvalid_d;

  logic              ar_hs, aw_hs, w_hs;
  logic              mem_we;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] ram_rdata;

  assign arready = (state_q == ST_IDLE);
  assign awready = (state_q == ST_IDLE) & ~arvalid;
  assign wready  = (state_q == ST_W_DATA);
  assign ar_hs   = arvalid & arready;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  // Steer the RAM to the incoming address on the AR edge so zero latency still sees fresh data.
  assign rd_idx = word_idx(ar_hs ? araddr[31:2] : addr_q[31:2]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    bresp_d  = bresp_q;
    bvalid_d = bvalid_q;
    mem_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          addr_d  = araddr;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY > 0) ? ST_R_WAIT : ST_R_RESP;
        end else if (aw_hs) begin
          addr_d  = awaddr;
          state_d = ST_W_DATA;
        end
      end
      ST_R_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = ST_R_RESP;
      end
      ST_R_RESP: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rdata_d  = addr_ok(addr_q) ? ram_rdata : '0;
          rresp_d  = addr_ok(addr_q) ? RESP_OKAY : RESP_SLVERR;
        end else if (rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_W_DATA: begin
        if (w_hs) begin
          wdata_d = wdata;
          wstrb_d = wstrb;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY > 0) ? ST_W_WAIT : ST_B_RESP;
        end
      end
      ST_W_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = ST_B_RESP;
      end
      ST_B_RESP: begin
        // Commit happens only here, so a reset during the wait leaves the array untouched.
        if (!bvalid_q) begin
          bvalid_d = 1'b1;
          mem_we   = addr_ok(addr_q);
          bresp_d  = addr_ok(addr_q) ? RESP_OKAY : RESP_SLVERR;
        end else if (bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
      bresp_q  <= bresp_d;
      bvalid_q <= bvalid_d;
    end
  end

  ysyx_25010008_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .rd_idx (rd_idx),
    .rd_data(ram_rdata),
    .wr_en  (mem_we),
    .wr_idx (word_idx(addr_q[31:2])),
    .wr_data(wdata_q),
    .wr_strb(wstrb_q)
  );

  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rvalid = rvalid_q;
  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;

endmodule

// File: tb/tb_ysyx_25010008_sram_slave.sv
// tb/tb_ysyx_25010008_sram_slave.sv - directed bench for the AXI-Lite SRAM slave (LATENCY 2 and 0)
module tb_ysyx_25010008_sram_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] araddr, rdata, awaddr, wdata;
  logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0] rresp, bresp;
  logic [3:0] wstrb;

  logic [31:0] z_araddr, z_rdata, z_awaddr, z_wdata;
  logic z_arvalid, z_arready, z_rvalid, z_rready, z_awvalid, z_awready, z_wvalid, z_wready, z_bvalid, z_bready;
  logic [1:0] z_rresp, z_bresp;
  logic [3:0] z_wstrb;

  int n_assert = 0;
  int n_fail = 0;

  ysyx_25010008_sram_slave #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  ysyx_25010008_sram_slave #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h8000_0000)) dut_z (
    .clk(clk), .rst(rst),
    .araddr(z_araddr), .arvalid(z_arvalid), .arready(z_arready),
    .rdata(z_rdata), .rresp(z_rresp), .rvalid(z_rvalid), .rready(z_rready),
    .awaddr(z_awaddr), .awvalid(z_awvalid), .awready(z_awready),
    .wdata(z_wdata), .wstrb(z_wstrb), .wvalid(z_wvalid), .wready(z_wready),
    .bresp(z_bresp), .bvalid(z_bvalid), .bready(z_bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout_fail(input string what);
    n_assert++;
    n_fail++;
    $display("FAIL timeout_%s: handshake did not occur within the cycle budget", what);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    awaddr = a; awvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("aw");
    tick();
    awvalid = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("w");
    tick();
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("b");
    resp = bresp;
    tick();
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("ar");
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin tick(); lat++; end
    if (lat >= 50) timeout_fail("r");
    d = rdata;
    resp = rresp;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_assert++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    n_assert++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid: got %b expected 0", bvalid); end
    n_assert++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    n_assert++; if (rresp !== 2'b00 || bresp !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got rresp=%b bresp=%b expected 00/00", rresp, bresp); end
    n_assert++; if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got ar=%b aw=%b w=%b expected 1/1/0", arready, awready, wready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    logic [1:0] resp;
    logic [31:0] d;
    int lat;
    axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, resp);
    n_assert++; if (resp !== 2'b00) begin n_fail++; $display("FAIL wr_bresp: got %b expected 00", resp); end
    axi_read(32'h8000_0010, d, resp, lat);
    n_assert++; if (lat != 3) begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    n_assert++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", d); end
    n_assert++; if (resp !== 2'b00) begin n_fail++; $display("FAIL rd_rresp: got %b expected 00", resp); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [31:0] d;
    int lat;
    axi_write(32'h8000_0020, 32'h1122_3344, 4'b1111, resp);
    axi_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, resp);
    n_assert++; if (resp !== 2'b00) begin n_fail++; $display("FAIL strb_bresp: got %b expected 00", resp); end
    axi_read(32'h8000_0020, d, resp, lat);
    n_assert++; if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strb_merge: got %h expected 11bb33dd", d); end
    axi_write(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, resp);
    n_assert++; if (resp !== 2'b00) begin n_fail++; $display("FAIL strb0_bresp: got %b expected 00", resp); end
    axi_read(32'h8000_0020, d, resp, lat);
    n_assert++; if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strb0_data: got %h expected 11bb33dd", d); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp;
    logic [31:0] d;
    int lat;
    axi_write(32'h8000_0FFC, 32'hCAFE_F00D, 4'b1111, resp);
    axi_read(32'h8000_0FFC, d, resp, lat);
    n_assert++; if (d !== 32'hCAFE_F00D || resp !== 2'b00) begin n_fail++; $display("FAIL last_word: got %h/%b expected cafef00d/00", d, resp); end
    axi_read(32'h8000_1000, d, resp, lat);
    n_assert++; if (d !== 32'h0 || resp !== 2'b10) begin n_fail++; $display("FAIL oor_read_hi: got %h/%b expected 00000000/10", d, resp); end
    n_assert++; if (lat != 3) begin n_fail++; $display("FAIL oor_latency: got %0d expected 3", lat); end
    axi_read(32'h7FFF_FFFC, d, resp, lat);
    n_assert++; if (d !== 32'h0 || resp !== 2'b10) begin n_fail++; $display("FAIL oor_read_lo: got %h/%b expected 00000000/10", d, resp); end
    axi_write(32'h7FFF_FFFC, 32'h0000_0000, 4'b1111, resp);
    n_assert++; if (resp !== 2'b10) begin n_fail++; $display("FAIL oor_bresp: got %b expected 10", resp); end
    axi_read(32'h8000_0FFC, d, resp, lat);
    n_assert++; if (d !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL oor_no_commit: got %h expected cafef00d", d); end
  endtask

  task automatic test_simultaneous();
    logic [1:0] resp;
    logic [31:0] d;
    int lat;
    int n;
    int aw_bad;
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    wdata = 32'h5555_AAAA; wstrb = 4'b1111; wvalid = 1'b1; bready = 1'b1;
    #0;
    n_assert++; if (arready !== 1'b1 || awready !== 1'b0) begin n_fail++; $display("FAIL sim_priority: got ar=%b aw=%b expected 1/0", arready, awready); end
    tick();
    arvalid = 1'b0;
    n = 0; aw_bad = 0;
    while (!rvalid && n < 50) begin
      if (awready !== 1'b0 || wready !== 1'b0) aw_bad++;
      tick(); n++;
    end
    if (n >= 50) timeout_fail("sim_r");
    n_assert++; if (aw_bad != 0) begin n_fail++; $display("FAIL sim_aw_blocked: got %0d cycles with awready/wready high expected 0", aw_bad); end
    n_assert++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sim_rdata: got %h expected deadbeef", rdata); end
    tick();
    n_assert++; if (awready !== 1'b1) begin n_fail++; $display("FAIL sim_aw_after: got %b expected 1", awready); end
    tick();
    awvalid = 1'b0;
    n_assert++; if (wready !== 1'b1) begin n_fail++; $display("FAIL sim_wready: got %b expected 1", wready); end
    tick();
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("sim_b");
    n_assert++; if (bresp !== 2'b00) begin n_fail++; $display("FAIL sim_bresp: got %b expected 00", bresp); end
    tick();
    axi_read(32'h8000_0030, d, resp, lat);
    n_assert++; if (d !== 32'h5555_AAAA) begin n_fail++; $display("FAIL sim_write_data: got %h expected 5555aaaa", d); end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp;
    int n;
    int bad;
    axi_write(32'h8000_0040, 32'h0BAD_CAFE, 4'b1111, resp);
    rready = 1'b0;
    araddr = 32'h8000_0040; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("bp_r");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rvalid !== 1'b1 || rdata !== 32'h0BAD_CAFE) bad++;
    end
    n_assert++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0 (rvalid=%b rdata=%h)", bad, rvalid, rdata); end
    rready = 1'b1;
    tick();
    n_assert++; if (rvalid !== 1'b0 || arready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got rvalid=%b arready=%b expected 0/1", rvalid, arready); end
  endtask

  task automatic test_reset_mid_write();
    logic [1:0] resp;
    logic [31:0] d;
    int lat;
    axi_write(32'h8000_0050, 32'h1234_5678, 4'b1111, resp);
    awaddr = 32'h8000_0050; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata = 32'hFFFF_FFFF; wstrb = 4'b1111; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_assert++; if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b0) begin n_fail++; $display("FAIL async_rst: got bvalid=%b awready=%b wready=%b expected 0/1/0", bvalid, awready, wready); end
    tick();
    rst = 1'b0;
    tick();
    axi_read(32'h8000_0050, d, resp, lat);
    n_assert++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL rst_no_commit: got %h expected 12345678", d); end
  endtask

  task automatic test_latency_zero();
    z_awaddr = 32'h8000_0008; z_awvalid = 1'b1; z_bready = 1'b1;
    tick();
    z_awvalid = 1'b0;
    z_wdata = 32'hA5A5_5A5A; z_wstrb = 4'b1111; z_wvalid = 1'b1;
    n_assert++; if (z_wready !== 1'b1) begin n_fail++; $display("FAIL z_wready: got %b expected 1", z_wready); end
    tick();
    z_wvalid = 1'b0;
    n_assert++; if (z_bvalid !== 1'b0) begin n_fail++; $display("FAIL z_bvalid_early: got %b expected 0", z_bvalid); end
    tick();
    n_assert++; if (z_bvalid !== 1'b1 || z_bresp !== 2'b00) begin n_fail++; $display("FAIL z_bvalid: got %b/%b expected 1/00", z_bvalid, z_bresp); end
    tick();
    z_araddr = 32'h8000_0008; z_arvalid = 1'b1; z_rready = 1'b1;
    tick();
    z_arvalid = 1'b0;
    n_assert++; if (z_rvalid !== 1'b0) begin n_fail++; $display("FAIL z_rvalid_early: got %b expected 0", z_rvalid); end
    tick();
    n_assert++; if (z_rvalid !== 1'b1 || z_rdata !== 32'hA5A5_5A5A || z_rresp !== 2'b00) begin n_fail++; $display("FAIL z_read: got %b/%h/%b expected 1/a5a55a5a/00", z_rvalid, z_rdata, z_rresp); end
    tick();
    n_assert++; if (z_rvalid !== 1'b0) begin n_fail++; $display("FAIL z_rvalid_clear: got %b expected 0", z_rvalid); end
  endtask

  initial begin
    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    z_araddr = '0; z_arvalid = 1'b0; z_rready = 1'b1;
    z_awaddr = '0; z_awvalid = 1'b0; z_wdata = '0; z_wstrb = '0; z_wvalid = 1'b0; z_bready = 1'b1;
    test_reset();
    test_write_read();
    test_strobe();
    test_out_of_range();
    test_simultaneous();
    test_backpressure();
    test_reset_mid_write();
    test_latency_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
